// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b, one bit per clock LSB first, through one full-subtractor cell with a registered borrow.
// Optional macro SERIAL_SUB_OVF_EN adds the registered signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,output logic             ovf
`endif
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready=1
    // SHIFT | one bit per edge through the subtractor cell
    // DONE  | result held with out_valid=1 until out_ready
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             bin_q,    bin_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic             ovf_q,    ovf_d;
`endif

    logic ai, bi, d_bit, bout;

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

    assign ai    = a_q[0];
    assign bi    = b_q[0];
    assign d_bit = ai ^ bi ^ bin_q;
    assign bout  = (~ai & bi) | (~(ai ^ bi) & bin_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                bin_d = bout;
                cnt_d = cnt_q + CW'(1);
                // The final bit lands directly in the output registers so diff/borrow only change on DONE entry.
                if (cnt_q == LAST_BIT) begin
                    state_d  = S_DONE;
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed scenarios plus random back-to-back operands against an integer model of a - b.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] ed, output logic eb, output logic eo);
        int r, sa, sb, sr;
        r  = int'(av) - int'(bv);
        ed = W'((r + (1 << W)) % (1 << W));
        eb = (r < 0);
        sa = av[W-1] ? int'(av) - (1 << W) : int'(av);
        sb = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
        sr = sa - sb;
        eo = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    endtask

    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
        int g;
        a = av;
        b = bv;
        in_valid = 1'b1;
        g = 0;
        while (in_ready !== 1'b1 && g < 50) begin
            step();
            g++;
        end
        total++;
        if (g >= 50) begin
            bad++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < W + 20) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++;
        if (diff !== '0) begin bad++; $display("FAIL reset_diff got=%h exp=00", diff); end
        total++;
        if (borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_gated got=%b exp=0", in_ready); end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
        step();
    endtask

    task automatic test_basic;
        int lat;
        out_ready = 1'b1;
        accept(8'h05, 8'h03);
        wait_result(lat);
        total++;
        if (lat !== W) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W); end
        total++;
        if (diff !== 8'h02) begin bad++; $display("FAIL basic_diff got=%h exp=02", diff); end
        total++;
        if (borrow !== 1'b0) begin bad++; $display("FAIL basic_borrow got=%b exp=0", borrow); end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_release_out_valid got=%b exp=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_back_in_idle in_ready=%b exp=1", in_ready); end
    endtask

    task automatic test_borrow_clear;
        int lat;
        accept(8'h03, 8'h05);
        wait_result(lat);
        total++;
        if (diff !== 8'hFE) begin bad++; $display("FAIL neg_diff got=%h exp=fe", diff); end
        total++;
        if (borrow !== 1'b1) begin bad++; $display("FAIL neg_borrow got=%b exp=1", borrow); end
        step();
        accept(8'h00, 8'h00);
        wait_result(lat);
        total++;
        if (diff !== 8'h00) begin bad++; $display("FAIL zero_diff got=%h exp=00", diff); end
        total++;
        if (borrow !== 1'b0) begin bad++; $display("FAIL zero_borrow_cleared got=%b exp=0", borrow); end
        step();
    endtask

    task automatic test_backpressure;
        int lat;
        logic [W-1:0] ed;
        logic eb, eo;
        out_ready = 1'b0;
        accept(8'h5A, 8'h3C);
        wait_result(lat);
        model(8'h5A, 8'h3C, ed, eb, eo);
        a = 8'h11;
        b = 8'h22;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || diff !== ed || borrow !== eb || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got v=%b d=%h br=%b rdy=%b exp v=1 d=%h br=%b rdy=0",
                         i, out_valid, diff, borrow, in_ready, ed, eb);
            end
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
        accept(8'h11, 8'h22);
        wait_result(lat);
        model(8'h11, 8'h22, ed, eb, eo);
        total++;
        if (lat !== W || diff !== ed || borrow !== eb) begin
            bad++;
            $display("FAIL stall_next_op got lat=%0d d=%h br=%b exp lat=%0d d=%h br=%b", lat, diff, borrow, W, ed, eb);
        end
        step();
    endtask

    task automatic test_reset_mid_shift;
        int lat;
        accept(8'h9C, 8'h21);
        step();
        step();
        rst_n = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        total++;
        if (diff !== 8'h00) begin bad++; $display("FAIL midrst_diff got=%h exp=00", diff); end
        rst_n = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_result got=%b exp=0", out_valid); end
        accept(8'hFF, 8'h01);
        wait_result(lat);
        total++;
        if (lat !== W || diff !== 8'hFE || borrow !== 1'b0) begin
            bad++;
            $display("FAIL midrst_after got lat=%0d d=%h br=%b exp lat=%0d d=fe br=0", lat, diff, borrow, W);
        end
        step();
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        int lat;
        logic [W-1:0] av [3];
        logic [W-1:0] bv [3];
        logic [W-1:0] xd [3];
        logic         xb [3];
        logic         xo [3];
        av = '{8'h80, 8'h7F, 8'h10};
        bv = '{8'h01, 8'hFF, 8'h01};
        xd = '{8'h7F, 8'h80, 8'h0F};
        xb = '{1'b0, 1'b1, 1'b0};
        xo = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            accept(av[i], bv[i]);
            wait_result(lat);
            total++;
            if (diff !== xd[i] || borrow !== xb[i] || ovf !== xo[i]) begin
                bad++;
                $display("FAIL ovf_case%0d got d=%h br=%b ovf=%b exp d=%h br=%b ovf=%b",
                         i, diff, borrow, ovf, xd[i], xb[i], xo[i]);
            end
            step();
        end
    endtask
`endif

    task automatic test_back_to_back;
        int lat;
        logic [W-1:0] av, bv, ed;
        logic eb, eo;
        out_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            av = W'($urandom);
            bv = W'($urandom);
            if (n % 50 == 0) bv = av;
            model(av, bv, ed, eb, eo);
            accept(av, bv);
            wait_result(lat);
            total++;
            if (lat !== W || diff !== ed || borrow !== eb) begin
                bad++;
                $display("FAIL rand_op n=%0d a=%h b=%h got lat=%0d d=%h br=%b exp lat=%0d d=%h br=%b",
                         n, av, bv, lat, diff, borrow, W, ed, eb);
            end
`ifdef SERIAL_SUB_OVF_EN
            total++;
            if (ovf !== eo) begin
                bad++;
                $display("FAIL rand_ovf n=%0d a=%h b=%h got=%b exp=%b", n, av, bv, ovf, eo);
            end
`endif
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_clear();
        test_backpressure();
        test_reset_mid_shift();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor that computes `a - b` one bit per clock, LSB first. Each bit goes through a single full-subtractor cell with a registered borrow. Operands enter and results leave through valid/ready handshakes. It is the subtract-side counterpart of the team's adder blocks, for datapaths that trade latency for area.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: synchronous, active-low reset, sampled on `clk` rising edge.
- `in_valid`  input  1: operands `a`, `b` are valid.
- `in_ready`  output  1: block can accept operands.
- `a`  input  WIDTH: minuend.
- `b`  input  WIDTH: subtrahend.
- `out_valid`  output  1: `diff`/`borrow` hold a completed result.
- `out_ready`  input  1: consumer accepts the result.
- `diff`  output  WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow`  output  1: final borrow-out; 1 iff `a < b` unsigned.
- `ovf`  output  1: signed overflow flag. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
  - capture `a`, `b` into shift registers;
  - clear the borrow flop and the bit counter;
  - go to SHIFT.
- SHIFT: on each edge, process the LSBs `ai`, `bi` and borrow-in `bin`:
  - `d = ai^bi^bin`;
  - `bout = (~ai&bi) | (~(ai^bi)&bin)`.
  - Shift `d` into the MSB of the result register; shift both operand registers right by 1; `bin <= bout`; increment the counter.
  - After the WIDTH-th bit, go to DONE.
- DONE: `out_valid`=1; `diff` = result register; `borrow` = final borrow.
  - On `out_valid`&&`out_ready`: go to IDLE.
- `in_ready` is 0 in SHIFT and DONE; `in_valid` is ignored there. No input queueing.
- Counter width is `$clog2(WIDTH)+1`; it never wraps within an operation.
- `diff` and `borrow` are registered. They hold their last value outside DONE; they are only meaningful while `out_valid`=1.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state → IDLE;
  - `out_valid`=0, `diff`=0, `borrow`=0, `ovf`=0.
  - `in_ready` is gated to 0 combinationally while `rst_n`=0.
- Accept edge E0 → SHIFT.
- Bits processed on edges E1..EWIDTH.
- `out_valid` rises after EWIDTH, so the result is visible WIDTH cycles after acceptance.
- The result is held stable for any number of `out_ready`=0 cycles.
- Output handshake edge → IDLE; `in_ready`=1 the next cycle.
- Minimum period between accepts: WIDTH+2 cycles (accept, WIDTH shifts, output handshake, back in IDLE).
- `rst_n`=0 during SHIFT or DONE aborts the operation. The partial result is discarded and no `out_valid` is produced for it.
- `in_valid` asserted in the same cycle as the output handshake is not accepted; it must persist until `in_ready`=1.

## Configuration
- Macro `SERIAL_SUB_OVF_EN`.
- Defined:
  - the `ovf` port exists;
  - it is registered at entry to DONE as `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the captured operand MSBs;
  - it is valid with `out_valid`.
- Undefined: no `ovf` port and no overflow logic. All other behaviour is identical.

## Test plan
- WIDTH=8, `a`=0x05, `b`=0x03, `out_ready`=1 → `out_valid` 8 cycles after accept, `diff`=0x02, `borrow`=0.
- `a`=0x03, `b`=0x05 → `diff`=0xFE, `borrow`=1; then `a`=0x00, `b`=0x00 → `diff`=0x00, `borrow`=0 (borrow cleared between operations).
- Backpressure: result ready, `out_ready`=0 for 5 cycles with `in_valid`=1 → `diff`/`borrow` stable, `in_ready`=0, no second accept. Then `out_ready`=1 → IDLE, next operand accepted.
- Reset mid-SHIFT: `rst_n`=0 at 3 cycles after accept → next cycle `out_valid`=0, `diff`=0. After release, `a`=0xFF, `b`=0x01 → `diff`=0xFE, `borrow`=0.
- `SERIAL_SUB_OVF_EN` defined: 0x80−0x01 → `diff`=0x7F, `borrow`=0, `ovf`=1; 0x7F−0xFF → `diff`=0x80, `borrow`=1, `ovf`=1; 0x10−0x01 → `ovf`=0.
- Random back-to-back operands (≥1000) against a reference model of `a-b` → all `diff`/`borrow` match, each latency exactly WIDTH cycles.
